washer_plant_model: RTL
=======================

WASHER_PLANT_MODEL -- requirements
Module: washer_plant_model

Interface
REQ-001 Parameter LEVEL_MAX, 8, water-level count that defines "full"; range 1..15.
REQ-002 Parameter WASH_CYCLES, 10, motor-on cycles before wash timeout; range 1..255.
REQ-003 Parameter SPIN_CYCLES, 5, spin cycles before spin timeout; range 1..255.
REQ-004 Parameter DOSE_CYCLES, 3, cycles from dose request to detergent confirmed; range 1..15.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-007 door_close_req  in  1  user door switch; 1 means close, 0 means open.
REQ-008 doorlock_check, motoron_check, fillvalue_check, drainvalue_check  in  1 each  controller actuator commands.
REQ-009 detergent_wash, checkwater_wash  in  1 each  controller phase flags: dose request and rinse phase.
REQ-010 closedoor, filledmachine, detergentadded, machinecycle_timeout, waterdrained, spin_timeout_check  out  1 each  sensor responses to the controller.
REQ-011 water_level  out  4  current fill level, 0..LEVEL_MAX.
REQ-012 fault  out  1  sticky illegal-command indicator.

Function
REQ-013 All outputs shall be registered, with no combinational path from any input to any output, so that no loop forms with a combinational controller.
REQ-014 Every output shall reflect state one clock after the causing input condition is sampled.
REQ-015 Door, closing: closedoor shall go to 1 the cycle after door_close_req=1.
REQ-016 Door, opening: closedoor shall go to 0 only when door_close_req=0 and doorlock_check=0; while doorlock_check=1 it shall hold 1.
REQ-017 Level rises: with fill=1 and drain=0, water_level shall increment by 1 per cycle and saturate at LEVEL_MAX.
REQ-018 Level falls: with drain=1 and fill=0, water_level shall decrement by 1 per cycle and saturate at 0.
REQ-019 Level holds: with fill and drain both 1, or both 0, water_level shall hold.
REQ-020 filledmachine shall be 1 exactly when registered water_level==LEVEL_MAX.
REQ-021 waterdrained shall be 1 exactly when registered water_level==0.
REQ-022 Dosing FSM states: IDLE, DOSING, DONE.
REQ-023 IDLE->DOSING on a detergent_wash 0->1 edge; the previous value is registered and reset to 0.
REQ-024 DOSING->DONE after DOSE_CYCLES cycles in DOSING.
REQ-025 DONE->IDLE when detergent_wash=0.
REQ-026 DOSING->IDLE if detergent_wash drops while in DOSING, with no confirmation issued.
REQ-027 detergentadded shall be 1 only in DONE; detergent_wash held at 1 shall not start a second dose.
REQ-028 Wash timer: 8-bit counter increments while motoron_check=1, saturating at WASH_CYCLES.
REQ-029 machinecycle_timeout shall be 1 while the wash counter==WASH_CYCLES.
REQ-030 The wash counter shall clear to 0 the cycle after motoron_check=0.
REQ-031 Spin timer: 8-bit counter increments while drainvalue_check=1, checkwater_wash=1 and water_level==0, saturating at SPIN_CYCLES.
REQ-032 spin_timeout_check shall be 1 while the spin counter==SPIN_CYCLES.
REQ-033 The spin counter shall clear when any spin-timer enable condition is false.
REQ-034 fault shall set on: fill and drain both 1; motoron_check=1 with water_level==0; motoron_check=1 with closedoor=0; fillvalue_check=1 with doorlock_check=0.
REQ-035 Once set, fault shall stay 1 until reset; it shall not change level, timer or dosing behaviour.
REQ-036 When several conditions hold in the same cycle, each counter and FSM shall update independently in that cycle; no arbitration applies.

Reset
REQ-037 On reset=0 at a clk edge: water_level, wash counter, spin counter = 0; dosing FSM = IDLE; closedoor, filledmachine, detergentadded, machinecycle_timeout, spin_timeout_check, fault = 0; waterdrained = 1.
REQ-038 Reset asserted mid-operation shall override every other input in that cycle.
REQ-039 Outputs shall hold their reset values while reset=0, regardless of activity on other inputs.

Verification
REQ-040 Fill: reset released, lock=1, fill=1 for 10 cycles -> water_level counts 1..8 and holds at 8; filledmachine=1 from the 8th cycle; waterdrained=0 from the 1st cycle; fault=0.
REQ-041 Drain: from level 8, drain=1 -> level 0 after 8 cycles; waterdrained=1. Then keep drain=1 with checkwater_wash=1 -> spin_timeout_check=1 on the 5th spin cycle; drop drain -> spin_timeout_check=0 next cycle.
REQ-042 Wash: door closed, level 8, motoron_check=1 -> machinecycle_timeout=1 after 10 cycles; motor=0 -> timeout 0 next cycle. Re-enable motor -> full 10 cycles again.
REQ-043 Dosing: detergent_wash 0->1 and held -> detergentadded=1 3 cycles later and held. Request drop -> 0 next cycle. Request held 20 cycles -> exactly one rising edge on detergentadded.
REQ-044 Door: lock=1 with door_close_req=0 -> closedoor stays 1. Lock=0 -> closedoor=0 next cycle. Fill=1 with lock=0 -> fault=1, held until reset.
REQ-045 Reset mid-wash: level 5, wash counter 4, reset=0 for one edge -> every output at its REQ-037 value on the next cycle.

Source files
------------

// File: rtl/washer_plant_model.sv
// washer_plant_model
// Cycle-level model of a washing machine's plant (door, water tank, detergent
// doser, motor and spin timers). It answers a washer controller's actuator
// commands with sensor responses. Every output comes straight from a flop, so
// a purely combinational controller can be wired around it without forming a
// loop.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   door_close_req      user door switch (1 = close, 0 = open)
//   doorlock_check      controller: door lock engaged
//   motoron_check       controller: drum motor on
//   fillvalue_check     controller: fill valve open
//   drainvalue_check    controller: drain valve open
//   detergent_wash      controller: detergent dose request (acts on 0->1 edge)
//   checkwater_wash     controller: rinse/spin phase flag
//   closedoor           sensor: door is closed
//   filledmachine       sensor: water_level == LEVEL_MAX
//   detergentadded      sensor: dose confirmed
//   machinecycle_timeout sensor: wash timer expired
//   waterdrained        sensor: water_level == 0
//   spin_timeout_check  sensor: spin timer expired
//   water_level[3:0]    current fill level, 0..LEVEL_MAX
//   fault               sticky illegal-command indicator
module washer_plant_model #(
  parameter int LEVEL_MAX   = 8,
  parameter int WASH_CYCLES = 10,
  parameter int SPIN_CYCLES = 5,
  parameter int DOSE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_close_req,
  input  logic       doorlock_check,
  input  logic       motoron_check,
  input  logic       fillvalue_check,
  input  logic       drainvalue_check,
  input  logic       detergent_wash,
  input  logic       checkwater_wash,
  output logic       closedoor,
  output logic       filledmachine,
  output logic       detergentadded,
  output logic       machinecycle_timeout,
  output logic       waterdrained,
  output logic       spin_timeout_check,
  output logic [3:0] water_level,
  output logic       fault
);

  localparam logic [3:0] LEVEL_FULL = 4'(LEVEL_MAX);
  localparam logic [7:0] WASH_MAX   = 8'(WASH_CYCLES);
  localparam logic [7:0] SPIN_MAX   = 8'(SPIN_CYCLES);
  // Dose counter starts at 0 on entry, so DOSING lasts DOSE_CYCLES clocks.
  localparam logic [3:0] DOSE_LAST  = 4'(DOSE_CYCLES - 1);

  typedef enum logic [1:0] {
    DOSE_IDLE,
    DOSE_DOSING,
    DOSE_DONE
  } dose_state_t;

  dose_state_t dose_state, dose_state_d;
  logic [3:0]  dose_cnt, dose_cnt_d;
  logic        detergent_prev;
  logic [7:0]  wash_cnt, wash_cnt_d;
  logic [7:0]  spin_cnt, spin_cnt_d;
  logic [3:0]  level_d;
  logic        closedoor_d;
  logic        fault_d;
  logic        spin_en;

  // Next-state logic. The flag outputs are registered from these next values
  // so they line up with the counters and level they describe.
  always_comb begin
    // NOTE: every always_comb target gets a default first; a missing branch
    // would otherwise infer a latch.
    level_d      = water_level;
    closedoor_d  = closedoor;
    wash_cnt_d   = 8'd0;
    spin_cnt_d   = 8'd0;
    spin_en      = drainvalue_check && checkwater_wash && (water_level == 4'd0);

    // Fill and drain together (or neither) leave the level unchanged.
    if (fillvalue_check && !drainvalue_check && (water_level != LEVEL_FULL))
      level_d = water_level + 4'd1;
    else if (drainvalue_check && !fillvalue_check && (water_level != 4'd0))
      level_d = water_level - 4'd1;

    // The lock keeps the door shut even if the user asks to open it.
    if (door_close_req)
      closedoor_d = 1'b1;
    else if (!doorlock_check)
      closedoor_d = 1'b0;

    if (motoron_check)
      wash_cnt_d = (wash_cnt == WASH_MAX) ? wash_cnt : wash_cnt + 8'd1;

    if (spin_en)
      spin_cnt_d = (spin_cnt == SPIN_MAX) ? spin_cnt : spin_cnt + 8'd1;

    // Illegal commands are judged against the registered plant state.
    fault_d = fault
            | (fillvalue_check && drainvalue_check)
            | (motoron_check && (water_level == 4'd0))
            | (motoron_check && !closedoor)
            | (fillvalue_check && !doorlock_check);
  end

  // Dosing FSM next-state.
  always_comb begin
    dose_state_d = dose_state;
    dose_cnt_d   = dose_cnt;
    unique case (dose_state)
      DOSE_IDLE: begin
        // Only a fresh request starts a dose; holding it high does not re-arm.
        if (detergent_wash && !detergent_prev) begin
          dose_state_d = DOSE_DOSING;
          dose_cnt_d   = 4'd0;
        end
      end
      DOSE_DOSING: begin
        if (!detergent_wash)
          dose_state_d = DOSE_IDLE;
        else if (dose_cnt == DOSE_LAST)
          dose_state_d = DOSE_DONE;
        else
          dose_cnt_d = dose_cnt + 4'd1;
      end
      DOSE_DONE: begin
        if (!detergent_wash)
          dose_state_d = DOSE_IDLE;
      end
      default: dose_state_d = DOSE_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and takes priority over every input.
    if (!reset) begin
      dose_state           <= DOSE_IDLE;
      dose_cnt             <= 4'd0;
      detergent_prev       <= 1'b0;
      wash_cnt             <= 8'd0;
      spin_cnt             <= 8'd0;
      water_level          <= 4'd0;
      closedoor            <= 1'b0;
      filledmachine        <= 1'b0;
      detergentadded       <= 1'b0;
      machinecycle_timeout <= 1'b0;
      waterdrained         <= 1'b1;
      spin_timeout_check   <= 1'b0;
      fault                <= 1'b0;
    end else begin
      dose_state           <= dose_state_d;
      dose_cnt             <= dose_cnt_d;
      detergent_prev       <= detergent_wash;
      wash_cnt             <= wash_cnt_d;
      spin_cnt             <= spin_cnt_d;
      water_level          <= level_d;
      closedoor            <= closedoor_d;
      filledmachine        <= (level_d == LEVEL_FULL);
      detergentadded       <= (dose_state_d == DOSE_DONE);
      machinecycle_timeout <= (wash_cnt_d == WASH_MAX);
      waterdrained         <= (level_d == 4'd0);
      spin_timeout_check   <= (spin_cnt_d == SPIN_MAX);
      fault                <= fault_d;
    end
  end

endmodule
